// File: rtl/key_pkg.sv
// Shared types and board-clock timing defaults for the push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } key_state_e;

    // 20 MHz board clock: 20 ms debounce, 0.5 s repeat delay, 0.1 s repeat period
    localparam int DEF_DEBOUNCE_CYCLES = 400000;
    localparam int DEF_REPEAT_DELAY    = 10000000;
    localparam int DEF_REPEAT_PERIOD   = 2000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, hold/repeat counter.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic hit
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX) + 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DLY_LAST = HW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [HW-1:0] PER_LAST = HW'(REPEAT_PERIOD - 1);
    localparam logic          RPT_EN   = (REPEAT_DELAY != 0);

    logic [1:0]    sync;
    logic          s;
    key_state_e    state;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    logic          rpt_phase;
    logic          press_hit;
    logic          rel_hit;
    logic          rpt_hit;

    assign s = sync[1];

    // Next-cycle pulse conditions, shared by the FSM and the top-level any_press register
    always_comb begin
        press_hit = (state == DB_PRESS) && s && (db_cnt == DB_LAST);
        rel_hit   = (state == DB_RELEASE) && !s && (db_cnt == DB_LAST);
        rpt_hit   = RPT_EN && (state == HELD) && s &&
                    (rpt_phase ? (hold_cnt == PER_LAST) : (hold_cnt == DLY_LAST));
        hit       = press_hit | rpt_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync      <= 2'b00;
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            rpt_phase <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            rpt       <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= press_hit;
            rel   <= rel_hit;
            rpt   <= rpt_hit;
            case (state)
                IDLE: begin
                    if (s) begin
                        state  <= DB_PRESS;
                        db_cnt <= DW'(1);
                    end
                end
                DB_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (press_hit) begin
                        state     <= HELD;
                        level     <= 1'b1;
                        hold_cnt  <= '0;
                        rpt_phase <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= DW'(1);
                    end else if (rpt_hit) begin
                        // reload: counter never runs past its target
                        hold_cnt  <= '0;
                        rpt_phase <= 1'b1;
                    end else if (RPT_EN) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DB_RELEASE: begin
                    // hold counter is frozen here so a release glitch resumes the repeat phase
                    if (s) begin
                        state <= HELD;
                    end else if (rel_hit) begin
                        state <= IDLE;
                        level <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-channel push-button conditioner: debounced levels, press/release/repeat pulses.
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 6,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              any_press
);

    logic [N_KEYS-1:0] hit;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (key_raw[g]),
            .level(key_level[g]),
            .press(key_press[g]),
            .rel  (key_release[g]),
            .rpt  (key_repeat[g]),
            .hit  (hit[g])
        );
    end

    // Registered from the channels' next-cycle pulse terms so it lines up with them
    always_ff @(posedge clk) begin
        if (rst) any_press <= 1'b0;
        else     any_press <= |hit;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Multi-channel push-button conditioner for the board's `swb` keys. It converts raw, bouncing, asynchronous button levels into synchronized, debounced levels, single-cycle press/release pulses, and optional hold-to-repeat pulses. It sits between the board pins and the board-level logic. Consumers then clock every register on `clk`, with no button-derived clocks. It is the input-side counterpart to the display driver: it is the path by which operator actions enter the design.

## Interface
- `N_KEYS`, default 6: number of independent button channels.
- `DEBOUNCE_CYCLES`, default 400000: consecutive stable samples needed to accept a level change (20 ms at 20 MHz). Must be ≥ 2.
- `REPEAT_DELAY`, default 10000000: cycles in HELD before the first repeat pulse (0.5 s). A value of 0 disables repeat.
- `REPEAT_PERIOD`, default 2000000: cycles between subsequent repeat pulses (0.1 s). Must be ≥ 1.
- `clk` in, 1: system clock, 20 MHz.
- `rst` in, 1: synchronous, active-high reset.
- `key_raw` in, N_KEYS: raw button levels. Asynchronous; 1 = pressed.
- `key_level` out, N_KEYS: debounced level per key.
- `key_press` out, N_KEYS: one-cycle pulse when a press is accepted.
- `key_release` out, N_KEYS: one-cycle pulse when a release is accepted.
- `key_repeat` out, N_KEYS: one-cycle auto-repeat pulse while a key is held.
- `any_press` out, 1: OR of `key_press` | `key_repeat`, registered in the same cycle as those pulses.

## Operation
- Each channel passes through a 2-flop synchronizer. Flop reset value is 0.
- Each channel has an independent FSM with four states: IDLE, DB_PRESS, HELD, DB_RELEASE.
- IDLE:
  - Synchronized input = 1 → DB_PRESS, debounce count = 1.
- DB_PRESS:
  - Input = 0 → IDLE. This is a bounce; no output.
  - Input = 1 and count = DEBOUNCE_CYCLES−1 → HELD, assert `key_press`, set `key_level`=1, clear the hold counter.
  - Otherwise, count +1.
- HELD:
  - Input = 0 → DB_RELEASE, debounce count = 1.
  - Otherwise, the hold counter advances.
  - If REPEAT_DELAY ≠ 0, `key_repeat` pulses when the hold counter reaches REPEAT_DELAY. It then pulses every REPEAT_PERIOD cycles thereafter.
  - The hold counter saturates/reloads; it never wraps into a spurious pulse.
- DB_RELEASE:
  - Input = 1 → HELD. `key_level` stays 1, with no press pulse. The hold/repeat phase continues from its current value.
  - Input = 0 and count = DEBOUNCE_CYCLES−1 → IDLE, assert `key_release`, set `key_level`=0.
  - Otherwise, count +1.
- `key_press`, `key_release` and `key_repeat` are mutually exclusive per channel in any cycle.
- Channels are fully independent. Simultaneous presses on several keys each produce their own pulse in the same cycle.
- Counter widths are `$clog2` of the relevant parameter plus 1. There is no arithmetic overflow at the maximum parameter values.

## Timing
- Reset: all FSMs go to IDLE, and all counters, synchronizer flops and outputs go to 0.
- Reset asserted mid-press or mid-hold gives no release pulse. A key still held after reset is reported as a new press after the full latency below.
- Press latency: raw input goes high and stays stable before clock edge E. `key_press` is then high in the cycle after edge E+1+DEBOUNCE_CYCLES, for exactly one cycle. Release latency is identical.
- `key_level` changes in the same cycle its press/release pulse is asserted.
- First `key_repeat` arrives REPEAT_DELAY cycles after `key_press`. Subsequent repeats are spaced REPEAT_PERIOD cycles apart.
- All outputs are registered, with no combinational path from `key_raw`.

## Structure
- Shared package `key_pkg`:
  - FSM state enum (IDLE, DB_PRESS, HELD, DB_RELEASE).
  - Default timing constants for the 20 MHz board clock.
- Sub-module `key_debounce_ch`: one channel, containing the synchronizer, FSM and counters.
- Top-level `key_debounce`: a generate loop over N_KEYS channel instances, plus the `any_press` OR-reduce register.

## Test plan
All scenarios use N_KEYS=6, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press on key 2, raw high for 30 cycles then low:
  - `key_press[2]` pulses once, 5 cycles after the first sampling edge.
  - `key_level[2]` goes 1.
  - `key_repeat[2]` pulses at +10, +13, +16… after the press.
  - After release, one `key_release[2]` pulse and `key_level[2]`=0.
- Bounce: raw 1,0,1,1,0 then 0 → no pulses and `key_level` stays 0. Then raw 1 for 6 cycles → exactly one press pulse.
- Release glitch: key held, raw 0 for 2 cycles then back to 1 → no release pulse, `key_level` stays 1, no extra press pulse.
- Keys 0 and 5 pressed on the same edge → `key_press[0]` and `key_press[5]` pulse in the same cycle, and `any_press`=1 for one cycle.
- `rst` asserted while key 3 is held, with key 3 still held after reset → all outputs 0 during reset, no release pulse, and a fresh `key_press[3]` 5 cycles after `rst` deasserts.
- REPEAT_DELAY=0 with a key held for 50 cycles → one press pulse and zero repeat pulses.
